// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 serialiser: queues scancode bytes in a small FIFO and sends
// 11-bit frames (start, 8 data LSB-first, odd parity, stop) on ps2_kbd_clk/ps2_kbd_data.
// Optional macro PS2_HOST_INHIBIT_EN adds ps2_clk_in: host clock-low inhibit with retry.
`timescale 1ns/1ps

module ps2_kbd_tx #(
  parameter int CLK_DIV   = 2000,
  parameter int FIFO_AW   = 4,
  parameter int GAP_CELLS = 2
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       wr,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic       busy,
`ifdef PS2_HOST_INHIBIT_EN
  input  logic       ps2_clk_in,
`endif
  output logic       ps2_kbd_clk,
  output logic       ps2_kbd_data
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int DW    = $clog2(2 * CLK_DIV);
  localparam int IW    = $clog2(((GAP_CELLS > 11) ? GAP_CELLS : 11) + 1);

  localparam logic [DW-1:0]      HALF_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]      CELL_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [IW-1:0]      STOP_IDX  = IW'(10);
  localparam logic [IW-1:0]      GAP_LAST  = IW'((GAP_CELLS > 0) ? GAP_CELLS - 1 : 0);
  localparam logic [FIFO_AW:0]   PTR_ONE   = (FIFO_AW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam state_t AFTER_FRAME = (GAP_CELLS > 0) ? GAP : IDLE;

  state_t state, state_n;

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wptr, rptr, wptr_n, rptr_n;
  logic             full_q, empty_q, ovf_q;
  logic             wr_ok, pop, start;

  logic [DW-1:0]    div;
  logic [IW-1:0]    idx;
  logic [10:0]      shift;
  logic             clk_q;
  logic             half_end, cell_end;

  logic [7:0]       head, next_byte;
  logic             line_ok, abort, retry_pend;

  assign head     = mem[rptr[FIFO_AW-1:0]];
  assign half_end = (div == HALF_LAST);
  assign cell_end = (div == CELL_LAST);

`ifdef PS2_HOST_INHIBIT_EN
  logic [1:0] clk_in_sync;
  logic [7:0] tx_byte;
  logic       retry_valid;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) clk_in_sync <= 2'b11;
    else        clk_in_sync <= {clk_in_sync[0], ps2_clk_in};
  end

  // The byte in flight is kept until its frame ends, so an aborted frame can be replayed.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      tx_byte     <= '0;
      retry_valid <= 1'b0;
    end else if (start) begin
      tx_byte     <= next_byte;
      retry_valid <= 1'b0;
    end else if (abort) begin
      retry_valid <= 1'b1;
    end
  end

  assign line_ok    = clk_in_sync[1];
  assign abort      = (state == SEND) && clk_q && !clk_in_sync[1];
  assign retry_pend = retry_valid;
  assign next_byte  = retry_valid ? tx_byte : head;
`else
  assign line_ok    = 1'b1;
  assign abort      = 1'b0;
  assign retry_pend = 1'b0;
  assign next_byte  = head;
`endif

  assign start = (state == IDLE) && line_ok && (retry_pend || !empty_q);
  assign wr_ok = wr && !full_q;

  // ---------------- FIFO ----------------
  always_comb begin
    wptr_n = wr_ok ? wptr + PTR_ONE : wptr;
    rptr_n = pop   ? rptr + PTR_ONE : rptr;
  end

  // NOTE: the storage array has no reset; only pointers define what is valid.
  always_ff @(posedge clk_sys) begin
    if (wr_ok) mem[wptr[FIFO_AW-1:0]] <= din;
  end

  // Flags are registered from the next pointers so they always match the pointer state.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      wptr    <= wptr_n;
      rptr    <= rptr_n;
      full_q  <= (wptr_n[FIFO_AW] != rptr_n[FIFO_AW]) &&
                 (wptr_n[FIFO_AW-1:0] == rptr_n[FIFO_AW-1:0]);
      empty_q <= (wptr_n == rptr_n);
      if (wr && full_q) ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = SEND;
      SEND: begin
        if (abort)                            state_n = AFTER_FRAME;
        else if (cell_end && idx == STOP_IDX) state_n = AFTER_FRAME;
      end
      GAP:  if (cell_end && idx == GAP_LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state != IDLE);
    pop  = start && !retry_pend;
  end

  // Bit-cell timing: divider runs 0..2*CLK_DIV-1; clock falls mid-cell, and the
  // next bit is shifted onto the data line on the same edge the clock rises.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      clk_q <= 1'b1;
      shift <= '1;
      div   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          div <= '0;
          idx <= '0;
          if (start) shift <= {1'b1, ~^next_byte, next_byte, 1'b0};
        end
        SEND: begin
          if (abort) begin
            clk_q <= 1'b1;
            shift <= '1;
            div   <= '0;
            idx   <= '0;
          end else if (cell_end) begin
            clk_q <= 1'b1;
            div   <= '0;
            shift <= {1'b1, shift[10:1]};
            idx   <= (idx == STOP_IDX) ? '0 : idx + IW'(1);
          end else begin
            div <= div + DW'(1);
            if (half_end) clk_q <= 1'b0;
          end
        end
        GAP: begin
          if (cell_end) begin
            div <= '0;
            idx <= idx + IW'(1);
          end else begin
            div <= div + DW'(1);
          end
        end
        default: begin
          clk_q <= 1'b1;
          shift <= '1;
          div   <= '0;
          idx   <= '0;
        end
      endcase
    end
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign overflow     = ovf_q;
  assign ps2_kbd_clk  = clk_q;
  assign ps2_kbd_data = shift[0];

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed bench for ps2_kbd_tx with CLK_DIV=4 (8-cycle bit-cells), 16-deep FIFO, 2 gap cells.
// Frames are decoded off the wire by a monitor; the inhibit case runs when PS2_HOST_INHIBIT_EN is set.
`timescale 1ns/1ps

module tb_ps2_kbd_tx;

  localparam int CLK_DIV   = 4;
  localparam int FIFO_AW   = 4;
  localparam int GAP_CELLS = 2;
  localparam int FRAME_GAP_CYC = 104;  // 11 cells * 8 + 2 gap cells * 8
  localparam int START_PERIOD  = 105;  // frame + gap + the one IDLE cycle that pops

  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] din     = 8'h00;
  logic       wr      = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       full, empty, overflow, busy, ps2_kbd_clk, ps2_kbd_data;
`ifdef PS2_HOST_INHIBIT_EN
  logic       host_clk = 1'b1;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  ps2_kbd_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW), .GAP_CELLS(GAP_CELLS)) dut (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .din          (din),
    .wr           (wr),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr),
    .busy         (busy),
`ifdef PS2_HOST_INHIBIT_EN
    .ps2_clk_in   (host_clk),
`endif
    .ps2_kbd_clk  (ps2_kbd_clk),
    .ps2_kbd_data (ps2_kbd_data)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Wire monitor: decodes frames at clock falls, checks data only moves with clock high.
  logic [10:0] frames[$];
  int          start_cyc[$];
  int          n_falls  = 0;
  int          bit_cnt  = 0;
  int          idle_run = 0;
  logic [10:0] acc      = '0;
  logic        prev_clk = 1'b1;
  logic        prev_data = 1'b1;

  always @(negedge clk_sys) begin
    if (!rst_n) begin
      bit_cnt  = 0;
      idle_run = 0;
    end else begin
      if (ps2_kbd_data !== prev_data) check("data_moves_clk_high", ps2_kbd_clk, 1'b1);
      if (prev_clk && !ps2_kbd_clk) begin
        n_falls++;
        if (bit_cnt == 0) start_cyc.push_back(cyc);
        acc[bit_cnt] = ps2_kbd_data;
        bit_cnt++;
        if (bit_cnt == 11) begin
          frames.push_back(acc);
          bit_cnt = 0;
        end
      end
      if (ps2_kbd_clk && ps2_kbd_data) idle_run++;
      else                             idle_run = 0;
      if (idle_run > 2 * CLK_DIV) bit_cnt = 0;  // drop any partial (aborted) frame
    end
    prev_clk  = ps2_kbd_clk;
    prev_data = ps2_kbd_data;
  end

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk_sys);
    din = b;
    wr  = 1'b1;
    @(negedge clk_sys);
    wr  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    while ((busy || !empty) && n < max_cyc) begin
      @(negedge clk_sys);
      n++;
    end
    check(tag, {30'b0, busy, ~empty}, 32'h0);
  endtask

  task automatic expect_frame(input string tag, input logic [10:0] exp);
    logic [10:0] got;
    check({tag, "_present"}, frames.size() > 0, 1'b1);
    if (frames.size() > 0) begin
      got = frames.pop_front();
      check(tag, got, exp);
    end
  endtask

  initial begin
    int f0, s0, n, c_p;

    // ---- reset state ----
    repeat (3) @(negedge clk_sys);
    check("rst_clk",      ps2_kbd_clk,  1'b1);
    check("rst_data",     ps2_kbd_data, 1'b1);
    check("rst_busy",     busy,         1'b0);
    check("rst_overflow", overflow,     1'b0);
    check("rst_full",     full,         1'b0);
    check("rst_empty",    empty,        1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // ---- single byte 0x1C, latency and frame length ----
    write_byte(8'h1C);
    check("t1_empty_after_wr", empty, 1'b0);
    check("t1_busy_before_pop", busy, 1'b0);
    f0 = n_falls;
    @(negedge clk_sys);
    check("t1_start_low", ps2_kbd_data, 1'b0);
    check("t1_busy", busy, 1'b1);
    check("t1_empty_after_pop", empty, 1'b1);
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    check("t1_frame_plus_gap", n, FRAME_GAP_CYC);
    check("t1_falls", n_falls - f0, 11);
    expect_frame("t1_frame_1c", 11'h438);

    // ---- back-to-back 0x00, 0xF0 ----
    @(negedge clk_sys);
    f0 = n_falls;
    s0 = start_cyc.size();
    din = 8'h00; wr = 1'b1;
    @(negedge clk_sys);
    din = 8'hF0;
    @(negedge clk_sys);
    wr = 1'b0;
    n = 0;
    while (start_cyc.size() < s0 + 1 && n < 50) begin @(negedge clk_sys); n++; end
    check("t2_second_queued", empty, 1'b0);
    n = 0;
    while (start_cyc.size() < s0 + 2 && n < 300) begin @(negedge clk_sys); n++; end
    check("t2_empty_after_pop2", empty, 1'b1);
    wait_idle("t2_idle", 300);
    check("t2_falls", n_falls - f0, 22);
    if (start_cyc.size() >= s0 + 2)
      check("t2_start_spacing", start_cyc[s0 + 1] - start_cyc[s0], START_PERIOD);
    else
      check("t2_two_starts", start_cyc.size() - s0, 2);
    expect_frame("t2_frame_00", 11'h600);
    expect_frame("t2_frame_f0", 11'h7E0);

    // ---- FIFO fill, overflow, set-beats-clear ----
    write_byte(8'hA0);
    @(negedge clk_sys);
    check("t3_first_popped", empty, 1'b1);
    for (int i = 0; i < 16; i++) begin
      din = 8'hB0 + 8'(i);
      wr  = 1'b1;
      @(negedge clk_sys);
    end
    wr = 1'b0;
    check("t3_full", full, 1'b1);
    check("t3_no_ovf_yet", overflow, 1'b0);
    write_byte(8'hEE);
    check("t3_ovf_set", overflow, 1'b1);
    check("t3_still_full", full, 1'b1);
    din = 8'hEF; wr = 1'b1; ovf_clr = 1'b1;
    @(negedge clk_sys);
    wr = 1'b0; ovf_clr = 1'b0;
    check("t3_set_beats_clr", overflow, 1'b1);
    ovf_clr = 1'b1;
    @(negedge clk_sys);
    ovf_clr = 1'b0;
    check("t3_ovf_cleared", overflow, 1'b0);
    wait_idle("t3_drain", 2200);
    check("t3_n_frames", frames.size(), 17);
    expect_frame("t3_frame_a0", 11'h740);
    for (int i = 0; i < 16; i++)
      expect_frame($sformatf("t3_frame_%0d", i), frame_of(8'hB0 + 8'(i)));

    // ---- async reset during bit 5 ----
    write_byte(8'h55);
    write_byte(8'h66);
    n = 0;
    while (bit_cnt != 6 && n < 200) begin @(negedge clk_sys); n++; end
    check("t4_in_bit5_clk_low", ps2_kbd_clk, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t4_async_clk", ps2_kbd_clk, 1'b1);
    check("t4_async_data", ps2_kbd_data, 1'b1);
    check("t4_async_empty", empty, 1'b1);
    check("t4_async_busy", busy, 1'b0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    f0 = n_falls;
    repeat (300) @(negedge clk_sys);
    check("t4_no_edges", n_falls - f0, 0);
    check("t4_no_frames", frames.size(), 0);
    check("t4_empty", empty, 1'b1);

    // ---- write landing exactly on the GAP->IDLE edge ----
    f0 = n_falls;
    s0 = start_cyc.size();
    write_byte(8'h11);
    @(negedge clk_sys);
    check("t5_first_start", ps2_kbd_data, 1'b0);
    c_p = cyc;
    while (cyc != c_p + FRAME_GAP_CYC - 1) @(negedge clk_sys);
    din = 8'h5A; wr = 1'b1;
    @(negedge clk_sys);
    wr = 1'b0;
    check("t5_idle_at_gap_end", busy, 1'b0);
    check("t5_clk_high_boundary", ps2_kbd_clk, 1'b1);
    @(negedge clk_sys);
    check("t5_start_next_edge", ps2_kbd_data, 1'b0);
    check("t5_busy_again", busy, 1'b1);
    wait_idle("t5_idle", 300);
    check("t5_falls", n_falls - f0, 22);
    if (start_cyc.size() >= s0 + 2)
      check("t5_start_spacing", start_cyc[s0 + 1] - start_cyc[s0], START_PERIOD);
    else
      check("t5_two_starts", start_cyc.size() - s0, 2);
    expect_frame("t5_frame_11", 11'h622);
    expect_frame("t5_frame_5a", 11'h6B4);

`ifdef PS2_HOST_INHIBIT_EN
    // ---- host inhibit during data bit 3 of 0x12, retry before 0x34 ----
    f0 = n_falls;
    write_byte(8'h12);
    write_byte(8'h34);
    n = 0;
    while (!(bit_cnt == 4 && ps2_kbd_clk) && n < 200) begin @(negedge clk_sys); n++; end
    host_clk = 1'b0;
    repeat (3) @(negedge clk_sys);
    host_clk = 1'b1;
    check("t6_aborted_lines_high", {30'b0, ps2_kbd_clk, ps2_kbd_data}, 32'h3);
    check("t6_busy_in_gap", busy, 1'b1);
    wait_idle("t6_idle", 600);
    check("t6_falls", n_falls - f0, 26);
    check("t6_n_frames", frames.size(), 2);
    expect_frame("t6_frame_12", 11'h624);
    expect_frame("t6_frame_34", 11'h468);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/ps2_kbd_tx.md
Name: ps2_kbd_tx

Overview:
- Device-side PS/2 serialiser: the transmitting end of the link that `keyboard` receives on.
- Takes scancode bytes from a small FIFO and drives `ps2_kbd_clk` / `ps2_kbd_data` with standard 11-bit frames: start 0, 8 data LSB-first, odd parity, stop 1.
- Used as a test/injection source for the keyboard path, and as the scancode generator behind a host-side key-macro engine.
- Runs on `clk_sys` with an internal bit-rate divider.

Parameters:
- CLK_DIV, 2000, `clk_sys` cycles per half bit-cell (48 MHz / 4000 = 12 kHz PS/2 clock); legal range 2..65535.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 bytes.
- GAP_CELLS, 2, idle bit-cells (clock and data high) inserted after every stop bit.

Ports:
- clk_sys  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- din  in  8  byte to queue.
- wr  in  1  single-cycle write strobe; queues din when not full.
- full  out  1  FIFO holds 2**FIFO_AW bytes.
- empty  out  1  FIFO holds 0 bytes.
- overflow  out  1  sticky; set when wr arrives while full.
- ovf_clr  in  1  clears overflow.
- busy  out  1  a frame or gap is in progress (state != IDLE).
- ps2_kbd_clk  out  1  PS/2 clock, idle high.
- ps2_kbd_data  out  1  PS/2 data, idle high.

Behaviour:
- Reset (async assert, sync release):
  - ps2_kbd_clk = 1, ps2_kbd_data = 1, busy = 0, overflow = 0, full = 0, empty = 1.
  - FIFO pointers = 0; state = IDLE; divider = 0.
  - Reset mid-frame abandons the frame immediately: both lines return to 1 asynchronously, and queued bytes are lost.
- FIFO:
  - Write pointer and read pointer are FIFO_AW+1 bits wide.
  - full = (ptr MSBs differ and low bits equal); empty = (pointers equal). Both are registered views of the pointers.
  - wr while full: byte dropped, overflow <= 1, write pointer unchanged. This holds even if a pop happens in the same cycle.
  - wr and pop in the same cycle while not full and not empty: both proceed, count unchanged.
  - overflow set and ovf_clr in the same cycle: set wins.
- States: IDLE, SEND, GAP.
  - IDLE:
    - If !empty, pop the head byte into shift[10:0] = {1, ~^byte, byte[7:0], 0} and go to SEND.
    - Set bit index = 0 and divider = 0.
    - ps2_kbd_data takes shift[0] (start bit = 0) on the same edge.
    - Latency: wr at edge N into an empty FIFO gives empty = 0 at N+1 and data low at N+2.
  - SEND: each bit-cell is 2*CLK_DIV cycles.
    - First half: clock high, data = current bit.
    - Second half: clock low, data held.
    - At divider == CLK_DIV-1: clock falls.
    - At divider == 2*CLK_DIV-1: clock rises, divider = 0, shift right, index + 1, and the data line updates to the next bit on that same edge.
    - After index 10 (stop bit) completes, go to GAP.
  - GAP:
    - Both lines high for GAP_CELLS*2*CLK_DIV cycles, then IDLE.
    - A byte waiting in the FIFO is popped on the first IDLE cycle; there is no extra delay.
- Parity: odd over 8 data bits (0x00 -> parity 1; 0x1C -> parity 0).
- Each frame produces exactly 11 falling edges of ps2_kbd_clk. Data is never changed while ps2_kbd_clk is low.
- busy = 1 throughout SEND and GAP.

Optional Feature:
- PS2_HOST_INHIBIT_EN: adds input `ps2_clk_in` (1 bit, the line as seen on the bus, synchronised internally with 2 flops).
- With the macro:
  - In IDLE, no pop occurs while the synchronised ps2_clk_in = 0.
  - In SEND, if ps2_clk_in = 0 during a clock-high half-cell, the frame aborts: lines go high, and state = GAP with the full GAP_CELLS.
  - The aborted byte is kept in a retry register and resent, from its start bit, before any further FIFO pop.
- Without the macro: the port is absent and transmission ignores the bus.

Test Plan:
- Reset, then write 0x1C -> 11 clock falls; data sampled at falls = 0,0,0,1,1,1,0,0,0,0,1 (parity 0); busy returns to 0 after GAP. With CLK_DIV = 4, frame + gap = 104 cycles.
- Write 0x00 then 0xF0 back-to-back -> two frames, parity bits 1 and 1, separated by exactly GAP_CELLS cells of idle high; empty = 1 after the second pop.
- Write 17 bytes with no drain (FIFO_AW = 4, first byte already popped) -> 16 held, full = 1. An 18th write sets overflow = 1, and that byte never appears on the wire. ovf_clr clears overflow.
- Deassert rst_n during bit 5 of a frame -> ps2_kbd_clk and ps2_kbd_data = 1 within 0 cycles (async); empty = 1, no further edges.
- Write 0x5A exactly when the previous frame's GAP ends -> start bit at the next edge; check no clock glitch at the boundary.
- (PS2_HOST_INHIBIT_EN) Hold ps2_clk_in = 0 during the data-bit-3 high phase of 0x12 -> abort, gap, then 0x12 resent complete before the queued 0x34.
